dff_delay_line: RTL
===================

DFF_DELAY_LINE -- requirements
Module: dff_delay_line

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, the data bits per stage.
REQ-002 The block SHALL take parameter DEPTH, default 4, the number of register stages (minimum 1).
REQ-003 The block SHALL take parameter RESET_VAL, default 0 (WIDTH bits), the data value loaded on reset or flush.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  advance enable; 0 = hold all stages.
REQ-007 flush  input  1  synchronous clear of all stages.
REQ-008 data_in  input  WIDTH  data entering stage 0.
REQ-009 valid_in  input  1  qualifies data_in.
REQ-010 data_out  output  WIDTH  data of stage DEPTH-1.
REQ-011 valid_out  output  1  valid bit of stage DEPTH-1.
REQ-012 count  output  $clog2(DEPTH+1)  number of stages currently holding valid data.
REQ-013 full  output  1  high when count == DEPTH.

Function
REQ-014 Each stage SHALL hold a WIDTH-bit data word and a 1-bit valid flag.
REQ-015 On a rising edge with en=1 and flush=0, stage 0 SHALL load {data_in, valid_in} and stage k SHALL load stage k-1, for k = 1..DEPTH-1.
REQ-016 On a rising edge with en=0 and flush=0, every stage SHALL hold its data and valid flag.
REQ-017 On a rising edge with flush=1, every stage SHALL load data RESET_VAL and valid 0, regardless of en; the valid_in beat on that edge is dropped.
REQ-018 Latency: a word accepted on edge N SHALL appear on data_out/valid_out after exactly DEPTH en=1 edges, stalled edges excluded.
REQ-019 data_out and valid_out SHALL be driven directly from stage DEPTH-1 registers, with no combinational path from any input.
REQ-020 count SHALL be a register updated on the same edge as the stages.
  - en=1, no flush: count + valid_in - valid_out(pre-edge).
  - flush: 0.
  - otherwise: unchanged.
REQ-021 count SHALL always equal the number of set stage valid flags and SHALL never exceed DEPTH or wrap.
REQ-022 full SHALL be combinational from count.
REQ-023 Invalid words (valid_in=0) SHALL still shift their data bits; consumers SHALL qualify data_out with valid_out.
REQ-024 With DEPTH=1, the block SHALL behave as a single enabled D flip-flop with a valid flag and 1-cycle latency.
REQ-025 DEPTH=0 SHALL be rejected at elaboration.

Reset
REQ-026 While rst=0, all stage data SHALL be RESET_VAL, all valid flags 0 and count 0, asynchronously and independent of clk.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight words; outputs SHALL read data_out=RESET_VAL, valid_out=0, count=0, full=0 until the first post-reset edge.
REQ-028 Reset deassertion SHALL take effect at the next rising edge; that edge obeys REQ-015..017.

Structure
REQ-029 Package dff_pkg SHALL hold the default WIDTH, DEPTH and RESET_VAL constants and a packed stage typedef {data, valid}.
REQ-030 One sub-module, dff_en_stage, SHALL implement a single WIDTH-bit stage with async active-low reset, enable and synchronous clear; DEPTH instances are generated.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Reset/stream: rst=0 then released; en=1, valid_in=1, data_in 0x11,0x22,0x33,0x44,0x55 on successive edges -> valid_out first high 4 edges after 0x11 with data_out=0x11, then 0x22..0x55 consecutively; count 1,2,3,4,4; full high from the 4th edge.
REQ-032 Stall: en=0 for 3 edges mid-stream -> data_out, valid_out and count frozen; resuming en=1 continues the sequence with no loss or duplication.
REQ-033 Bubble: valid_in pattern 1,0,1,0 with data 0xA0..0xA3 -> valid_out pattern 1,0,1,0 starting 4 edges later; count never exceeds 2.
REQ-034 Flush with en=1, valid_in=1, count=3 -> next edge: count=0, valid_out=0, data_out=RESET_VAL; flushed-edge data never appears.
REQ-035 Async reset: rst pulled low between edges with count=4 -> immediately count=0, valid_out=0, full=0, with no clk edge required.
REQ-036 Scoreboard: random en/valid_in/flush for 1000 cycles at DEPTH=1 and DEPTH=4 -> output matches a reference queue model and count equals the popcount of stage valid flags every cycle.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared defaults and stage record for the enabled DFF delay line.
package dff_pkg;
  localparam int              DFLT_WIDTH     = 8;
  localparam int              DFLT_DEPTH     = 4;
  localparam logic [DFLT_WIDTH-1:0] DFLT_RESET_VAL = '0;

  typedef struct packed {
    logic [DFLT_WIDTH-1:0] data;
    logic                  valid;
  } stage_t;
endpackage

// File: rtl/dff_en_stage.sv
// One delay-line stage: data word plus valid flag, with enable and sync clear.
module dff_en_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             vld_d,
  output logic [WIDTH-1:0] q,
  output logic             vld_q
);
  // Clear wins over enable so a flush always empties the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= RESET_VAL;
      vld_q <= 1'b0;
    end else if (clr) begin
      q     <= RESET_VAL;
      vld_q <= 1'b0;
    end else if (en) begin
      q     <= d;
      vld_q <= vld_d;
    end
  end
endmodule

// File: rtl/dff_delay_line.sv
// DEPTH-stage enabled shift register with per-stage valid and occupancy count.
module dff_delay_line
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFLT_WIDTH,
  parameter int               DEPTH     = DFLT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFLT_RESET_VAL)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);
  localparam int CW = $clog2(DEPTH+1);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("dff_delay_line: DEPTH must be at least 1");
    end
  endgenerate

  logic [DEPTH-1:0][WIDTH-1:0] stg_data;
  logic [DEPTH-1:0]            stg_vld;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      logic [WIDTH-1:0] d;
      logic             vd;
      if (k == 0) begin : g_head
        assign d  = data_in;
        assign vd = valid_in;
      end else begin : g_tail
        assign d  = stg_data[k-1];
        assign vd = stg_vld[k-1];
      end
      dff_en_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (flush),
        .d     (d),
        .vld_d (vd),
        .q     (stg_data[k]),
        .vld_q (stg_vld[k])
      );
    end
  endgenerate

  assign data_out  = stg_data[DEPTH-1];
  assign valid_out = stg_vld[DEPTH-1];

  // Incremental occupancy: one word in at the head, one out at the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count <= '0;
    else if (flush) count <= '0;
    else if (en)    count <= count + CW'(valid_in) - CW'(valid_out);
  end

  assign full = (count == CW'(DEPTH));
endmodule
